// File: rtl/gcd_rr_scheduler.sv
// gcd_rr_scheduler
//   Round-robin front end that shares one subtractive GCD engine among
//   N_REQ requesters. A granted job is dispatched as: engine clear, operand A
//   with a start pulse, operand B, then a RUN phase that ends on engine done
//   or on a saturating timeout. The result is returned with a one-cycle,
//   one-hot ack to the granted requester.
//
//   Optional build macro GCD_ZERO_GUARD_EN: when defined, a job with a zero
//   operand is answered directly (result = A|B, err = 0) one cycle after
//   grant, without touching the engine. When undefined, such a job is
//   dispatched normally and ends by timeout.
//
// Ports
//   clk, rst      clock (rising edge), synchronous active-high reset
//   req[N_REQ]    level job request per requester
//   opa, opb      packed operands, requester i at [i*W +: W]
//   ack[N_REQ]    one-hot job-complete pulse
//   result[W]     GCD result, valid with ack and held until the next ack
//   err           valid with ack, 1 = job aborted by timeout
//   busy          high whenever the scheduler is not idle
//   gcd_clr       one-cycle engine clear
//   gcd_start     engine start pulse (accompanies operand A)
//   gcd_din[W]    engine operand bus
//   gcd_done      engine done (level), gcd_result valid while high
//   gcd_result[W] engine result
module gcd_rr_scheduler #(
    parameter int N_REQ       = 4,
    parameter int W           = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] opa,
    input  logic [N_REQ*W-1:0] opb,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       result,
    output logic               err,
    output logic               busy,
    output logic               gcd_clr,
    output logic               gcd_start,
    output logic [W-1:0]       gcd_din,
    input  logic               gcd_done,
    input  logic [W-1:0]       gcd_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    // Counter value seen in the last permitted RUN cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_A,
        LOAD_B,
        RUN,
        RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   gidx;
    logic [W-1:0]    a_lat;
    logic [W-1:0]    b_lat;
    logic [CW-1:0]   cnt;

    logic            any_req;
    logic [IW-1:0]   gnt_idx;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Saturating increment: the RUN counter never wraps.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}})
            return v;
        return v + CW'(1);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: first asserted request at or after rr+1, wrapping.
    // The loop runs from the farthest candidate to the nearest so the
    // nearest one is the final assignment.
    always_comb begin
        any_req = 1'b0;
        gnt_idx = rr;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(rr) + k) % N_REQ]) begin
                any_req = 1'b1;
                gnt_idx = IW'((int'(rr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        sel_a = opa[int'(gnt_idx)*W +: W];
        sel_b = opb[int'(gnt_idx)*W +: W];
    end

    // Outputs are registered and set on the edge that enters the state
    // they belong to, so each is visible for exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr        <= IW'(N_REQ - 1);
            cnt       <= '0;
            ack       <= '0;
            result    <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            gcd_clr   <= 1'b0;
            gcd_start <= 1'b0;
            gcd_din   <= '0;
        end else begin
            ack       <= '0;
            gcd_clr   <= 1'b0;
            gcd_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gidx  <= gnt_idx;
                        a_lat <= sel_a;
                        b_lat <= sel_b;
                        rr    <= gnt_idx;
                        busy  <= 1'b1;
`ifdef GCD_ZERO_GUARD_EN
                        if (sel_a == '0 || sel_b == '0) begin
                            // A|B is the nonzero operand, or 0 if both are zero.
                            state  <= RESP;
                            ack    <= onehot(gnt_idx);
                            result <= sel_a | sel_b;
                            err    <= 1'b0;
                        end else begin
                            state   <= CLEAR;
                            gcd_clr <= 1'b1;
                        end
`else
                        state   <= CLEAR;
                        gcd_clr <= 1'b1;
`endif
                    end
                end
                CLEAR: begin
                    state     <= LOAD_A;
                    gcd_din   <= a_lat;
                    gcd_start <= 1'b1;
                end
                LOAD_A: begin
                    state   <= LOAD_B;
                    gcd_din <= b_lat;
                end
                LOAD_B: begin
                    state <= RUN;
                    cnt   <= '0;
                end
                RUN: begin
                    cnt <= sat_inc(cnt);
                    // done takes precedence over a coincident timeout
                    if (gcd_done) begin
                        state  <= RESP;
                        ack    <= onehot(gidx);
                        result <= gcd_result;
                        err    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= RESP;
                        ack    <= onehot(gidx);
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
module tb_gcd_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int T  = 16;
    localparam int OW = N * W;
`ifdef GCD_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [OW-1:0] opa = '0;
    logic [OW-1:0] opb = '0;
    logic [N-1:0]  ack;
    logic [W-1:0]  result;
    logic          err;
    logic          busy;
    logic          gcd_clr;
    logic          gcd_start;
    logic [W-1:0]  gcd_din;
    logic          gcd_done;
    logic [W-1:0]  gcd_result;

    int n_tests = 0;
    int n_fail  = 0;

    gcd_rr_scheduler #(.N_REQ(N), .W(W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .req(req), .opa(opa), .opb(opb),
        .ack(ack), .result(result), .err(err), .busy(busy),
        .gcd_clr(gcd_clr), .gcd_start(gcd_start), .gcd_din(gcd_din),
        .gcd_done(gcd_done), .gcd_result(gcd_result)
    );

    always #5 clk = ~clk;

    function automatic int gcd_ref(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural engine: clear, capture A with start, B on the next cycle,
    // then raise done eng_lat cycles into RUN (0 = never). Zero operands
    // never finish, like the real subtractive engine.
    int           eng_lat = 1;
    int           e_ph    = 0;
    int           e_rc    = 0;
    logic [W-1:0] e_a     = '0;
    logic [W-1:0] e_b     = '0;
    int           clr_cnt   = 0;
    int           start_cnt = 0;

    always @(posedge clk) begin
        if (gcd_clr)   clr_cnt   <= clr_cnt + 1;
        if (gcd_start) start_cnt <= start_cnt + 1;
        if (rst || gcd_clr) begin
            e_ph <= 0;
            e_rc <= 0;
        end else if (gcd_start) begin
            e_a  <= gcd_din;
            e_ph <= 1;
        end else if (e_ph == 1) begin
            e_b  <= gcd_din;
            e_ph <= 2;
            e_rc <= 1;
        end else if (e_ph == 2) begin
            e_rc <= e_rc + 1;
        end
    end

    assign gcd_done   = (e_ph == 2) && (eng_lat != 0) && (e_rc >= eng_lat) &&
                        (e_a != '0) && (e_b != '0);
    assign gcd_result = gcd_done ? W'(gcd_ref(int'(e_a), int'(e_b))) : W'('hA5);

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    int           rr_m = N - 1;
    logic [W-1:0] opa_m [N];
    logic [W-1:0] opb_m [N];

    function automatic int model_grant(input logic [N-1:0] r, input int rr);
        for (int k = 1; k <= N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic predict(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           output int L, output int res, output int er, output bit disp);
        if (GUARD && (a == '0 || b == '0)) begin
            L = 1; res = int'(a | b); er = 0; disp = 1'b0;
        end else begin
            disp = 1'b1;
            if (a != '0 && b != '0 && lat != 0 && lat <= T) begin
                L = 4 + lat; res = gcd_ref(int'(a), int'(b)); er = 0;
            end else begin
                L = 4 + T; res = 0; er = 1;
            end
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            opa[i*W +: W] = opa_m[i];
            opb[i*W +: W] = opb_m[i];
        end
    endtask

    task automatic run_job(input logic [N-1:0] r, input int lat, input bit scramble);
        int g, L, res, er, n, c0, s0;
        bit disp, got;
        logic [W-1:0] a, b;
        @(negedge clk);
        pack_ops();
        eng_lat = lat;
        req = r;
        g = model_grant(r, rr_m);
        a = opa_m[g];
        b = opb_m[g];
        predict(a, b, lat, L, res, er, disp);
        c0 = clr_cnt;
        s0 = start_cnt;
        n = 0;
        got = 1'b0;
        while (n < L + 8 && !got) begin
            @(negedge clk);
            n++;
            if (ack != '0) got = 1'b1;
            else if (scramble) begin
                req = req & N'($urandom);
                opa = OW'($urandom);
                opb = OW'($urandom);
            end
        end
        chk("ack_seen", int'(got), 1);
        if (got) begin
            chk("ack_vec", int'(ack), 1 << g);
            chk("latency", n, L);
            chk("result", int'(result), res);
            chk("err", int'(err), er);
            chk("busy_in_ack", int'(busy), 1);
        end
        rr_m = g;
        req = '0;
        @(negedge clk);
        chk("ack_one_cycle", int'(ack), 0);
        chk("busy_after", int'(busy), 0);
        chk("clr_pulses", clr_cnt - c0, disp ? 1 : 0);
        chk("start_pulses", start_cnt - s0, disp ? 1 : 0);
        if (disp) begin
            chk("din_a", int'(e_a), int'(a));
            chk("din_b", int'(e_b), int'(b));
        end
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        opa_m[i] = W'(a);
        opb_m[i] = W'(b);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_clr"}, int'(gcd_clr), 0);
        chk({tag, "_start"}, int'(gcd_start), 0);
        chk({tag, "_din"}, int'(gcd_din), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, n, exp_n;
        bit seen;
        for (int i = 0; i < N; i++) set_ops(i, 7 * (i + 1), 21);

        // Reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        rr_m = N - 1;

        // Single job: 12, 18, done after 3 RUN cycles
        set_ops(0, 12, 18);
        run_job(4'b0001, 3, 1'b0);

        // Timeout, and the done/timeout boundary
        set_ops(1, 35, 21);
        run_job(4'b0010, 0, 1'b0);
        set_ops(2, 48, 36);
        run_job(4'b0100, T, 1'b0);
        set_ops(3, 48, 36);
        run_job(4'b1000, T + 1, 1'b0);

        // Zero operands
        set_ops(0, 0, 9);
        run_job(4'b0001, 2, 1'b0);
        set_ops(1, 0, 0);
        run_job(4'b0010, 2, 1'b0);

        // Fairness: all requests held, instant engine
        for (int i = 0; i < N; i++) set_ops(i, 6 * (i + 2), 4 * (i + 1));
        eng_lat = 1;
        @(negedge clk);
        pack_ops();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            g = model_grant(4'b1111, rr_m);
            exp_n = (j == 0) ? 5 : 6;
            n = 0;
            seen = 1'b0;
            while (n < 20 && !seen) begin
                @(negedge clk);
                n++;
                if (ack != '0) seen = 1'b1;
            end
            chk("fair_ack", int'(ack), 1 << g);
            chk("fair_gap", n, exp_n);
            chk("fair_result", int'(result), gcd_ref(int'(opa_m[g]), int'(opb_m[g])));
            rr_m = g;
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Drop request mid-job
        set_ops(2, 45, 30);
        run_job(4'b0100, 4, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_regrant", int'(busy), 0);

        // Reset during RUN
        set_ops(2, 40, 24);
        eng_lat = 0;
        @(negedge clk);
        pack_ops();
        req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        if (ack != '0) seen = 1'b1;
        check_idle_outputs("midrst");
        rst = 1'b0;
        rr_m = N - 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack != '0) seen = 1'b1;
        end
        chk("midrst_no_ack", int'(seen), 0);
        set_ops(1, 27, 18);
        set_ops(3, 50, 20);
        run_job(4'b1010, 2, 1'b0);

        // Randomized jobs
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                int gg;
                gg = $urandom_range(1, 12);
                set_ops(i, gg * $urandom_range(0, 20), gg * $urandom_range(0, 20));
            end
            run_job(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(1, T + 4),
                    1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
- Round-robin scheduler sharing one subtractive GCD engine (controller plus datapath) among N_REQ requesters.
- Grants one requester at a time and clears the engine.
- Feeds operand A then operand B over the engine's shared input bus, then waits for done or timeout.
- Returns the result with a one-cycle ack to the granted requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width.
- TIMEOUT_CYC, 1023, maximum RUN cycles before the job is aborted (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester job request, level.
- opa  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- opb  in  N_REQ*W  operand B, same packing.
- ack  out  N_REQ  one-hot, one-cycle job-complete pulse.
- result  out  W  GCD result; valid in the ack cycle, held until the next ack.
- err  out  1  valid with ack; 1 = timeout abort.
- busy  out  1  high in every state except IDLE.
- gcd_clr  out  1  one-cycle engine clear (returns the engine controller to its load-A state).
- gcd_start  out  1  engine start pulse.
- gcd_din  out  W  engine input bus.
- gcd_done  in  1  engine done, level.
- gcd_result  in  W  engine result, valid while gcd_done=1.

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: ack=0, result=0, err=0, busy=0, gcd_clr=0, gcd_start=0, gcd_din=0.
  - Internal: state=IDLE, rr pointer=N_REQ-1 (requester 0 has top priority first), timeout counter=0.
  - Reset mid-job aborts the job with no ack.
- All outputs registered.
- States: IDLE, CLEAR, LOAD_A, LOAD_B, RUN, RESP.
- IDLE:
  - If any req is high, grant the first requester at or after rr+1 (wrapping).
  - Latch the grant index, opa and opb into internal registers; set rr=grant; go to CLEAR.
  - Otherwise stay in IDLE.
- Operands are latched at grant. A requester changing operands or dropping req after grant does not affect the job; ack still pulses.
- CLEAR: gcd_clr=1 for one cycle -> LOAD_A.
- LOAD_A: gcd_din=latched A, gcd_start=1 for one cycle -> LOAD_B.
- LOAD_B: gcd_din=latched B, gcd_start=0 -> RUN, counter cleared.
- RUN:
  - gcd_din holds B; the counter increments each cycle.
  - gcd_done=1 -> capture gcd_result, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYC without done -> result=0, err=1, go to RESP.
  - done and timeout in the same cycle -> done wins.
- RESP: ack[grant]=1 for exactly one cycle, result and err valid -> IDLE.
- Minimum latency: grant cycle to ack = 5 cycles (done seen in the first RUN cycle).
- A requester that keeps req high after ack is re-eligible immediately, but rr has advanced past it. Starvation-free: any asserted req is served within N_REQ jobs.
- IDLE to grant takes one cycle; there is no back-to-back grant in the RESP cycle.
- Counter width is clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- busy falls in the cycle the state returns to IDLE.

Optional Feature:
- Macro: GCD_ZERO_GUARD_EN.
- Defined:
  - At grant, if latched A==0 or B==0, skip CLEAR/LOAD/RUN and go directly to RESP on the next cycle.
  - Result = A|B (the nonzero operand; 0 if both are zero), err=0.
  - gcd_clr and gcd_start are not pulsed. Grant-to-ack = 1 cycle.
- Not defined:
  - Zero operands are dispatched normally.
  - The subtractive engine never asserts done, so the job ends by timeout: result=0, err=1.

Test Plan:
- Single job:
  - Stimulus: req[0]=1, A=12, B=18; engine model asserts done with 6 after 3 RUN cycles.
  - Response: gcd_clr then gcd_start pulse once each; gcd_din=12 then 18; ack=4'b0001 at grant+7; result=6; err=0.
- Fairness:
  - Stimulus: req=4'b1111 held, engine returns instantly.
  - Response: ack order 0,1,2,3,0, each 5 cycles after its grant; no requester is served twice before all the others.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, engine never asserts done.
  - Response: ack after 16 RUN cycles with result=0, err=1; busy drops on the next cycle.
- Zero operand:
  - Stimulus: A=0, B=9.
  - Response with GCD_ZERO_GUARD_EN: ack 1 cycle after grant, result=9, no gcd_start.
  - Response without the macro: full dispatch, timeout, err=1.
- Reset mid-RUN:
  - Stimulus: assert rst during RUN, then req=4'b1010.
  - Response: all outputs 0 with no ack; next grant goes to requester 1.
- Drop req mid-job:
  - Stimulus: req[2] falls during LOAD_B.
  - Response: ack[2] still pulses with the correct result; requester 2 is not regranted.
